tmr_apb_sequencer: RTL

TMR_APB_SEQUENCER -- requirements
Module: tmr_apb_sequencer

---
 rtl/tmr_apb_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tmr_apb_sequencer.sv
// tmr_apb_sequencer: programs a timer over APB (load, run), collects OVF/UDF events by reading
//   and clearing TSR, then stops the timer.
// Latency: each APB transfer takes one gap cycle (PSEL=0), one SETUP cycle and one or more ACCESS cycles.
// Backpressure: ACCESS is held while PREADY=0; start is ignored while busy; abort waits for the current transfer to end.
// Ports: PCLK clock, PRESET async active-high reset; start/abort control pulses; cfg_* sequence
//   setup, latched on an accepted start; TMR_OVF/TMR_UDF timer flag levels; P* APB master port;
//   busy/done/err/evt_cnt/last_tsr sequence status.
module tmr_apb_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TDR = 'h00,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TCR = 'h01,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TSR = 'h02
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_load,
  input  logic                  cfg_down,
  input  logic [1:0]            cfg_cks,
  input  logic [7:0]            cfg_evt_target,
  input  logic                  TMR_OVF,
  input  logic                  TMR_UDF,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            evt_cnt,
  output logic [DATA_WIDTH-1:0] last_tsr
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_TDR   = 3'd1;
  localparam logic [2:0] S_WR_LOAD  = 3'd2;
  localparam logic [2:0] S_WR_RUN   = 3'd3;
  localparam logic [2:0] S_WAIT_EVT = 3'd4;
  localparam logic [2:0] S_RD_TSR   = 3'd5;
  localparam logic [2:0] S_WR_CLR   = 3'd6;
  localparam logic [2:0] S_WR_STOP  = 3'd7;

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic [DATA_WIDTH-1:0] load_q;
  logic                  down_q;
  logic [1:0]            cks_q;
  logic [7:0]            tgt_q;
  logic                  flag_q;
  logic                  abort_pend;
  logic                  evt_edge;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic                  x_wr;
  logic [DATA_WIDTH-1:0] x_dat;

  // TCR image: LOAD bit7, DOWN bit5, EN bit4, CKS bits1:0, everything else zero.
  function automatic logic [DATA_WIDTH-1:0] tcr_val(input logic ld, input logic en,
                                                    input logic dn, input logic [1:0] ck);
    logic [7:0] v;
    v = {ld, 1'b0, dn, en, 2'b00, ck};
    return DATA_WIDTH'(v);
  endfunction

  assign busy     = (state != S_IDLE);
  // The registered flag copy runs in every state, so an edge seen outside WAIT_EVT is consumed.
  assign evt_edge = (TMR_OVF | TMR_UDF) & ~flag_q;

  // Address/direction/data of the transfer owned by the current state.
  always_comb begin
    x_addr = ADDR_TCR;
    x_wr   = 1'b1;
    x_dat  = '0;
    case (state)
      S_WR_TDR:  begin x_addr = ADDR_TDR; x_dat = load_q; end
      S_WR_LOAD: x_dat = tcr_val(1'b1, 1'b0, down_q, cks_q);
      S_WR_RUN:  x_dat = tcr_val(1'b0, 1'b1, down_q, cks_q);
      S_RD_TSR:  begin x_addr = ADDR_TSR; x_wr = 1'b0; end
      S_WR_CLR:  x_addr = ADDR_TSR;
      S_WR_STOP: x_dat = tcr_val(1'b0, 1'b0, down_q, cks_q);
      default:   x_dat = '0;
    endcase
  end

  // Successor state once the current transfer completes. An error or a pending/arriving
  // abort diverts to WR_STOP, except from WR_STOP itself which always ends the sequence.
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_WR_TDR:  nxt = S_WR_LOAD;
      S_WR_LOAD: nxt = S_WR_RUN;
      S_WR_RUN:  nxt = S_WAIT_EVT;
      S_RD_TSR:  nxt = S_WR_CLR;
      S_WR_CLR:  nxt = (evt_cnt == tgt_q) ? S_WR_STOP : S_WAIT_EVT;
      default:   nxt = S_IDLE;
    endcase
    if (state != S_WR_STOP && (PSLVERR || abort_pend || abort))
      nxt = S_WR_STOP;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= S_IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      evt_cnt    <= '0;
      last_tsr   <= '0;
      flag_q     <= 1'b0;
      abort_pend <= 1'b0;
      load_q     <= '0;
      down_q     <= 1'b0;
      cks_q      <= '0;
      tgt_q      <= '0;
    end else begin
      done   <= 1'b0;
      flag_q <= TMR_OVF | TMR_UDF;
      case (state)
        S_IDLE: begin
          // start beats a simultaneous abort: abort is simply not looked at here.
          if (start) begin
            load_q     <= cfg_load;
            down_q     <= cfg_down;
            cks_q      <= cfg_cks;
            tgt_q      <= (cfg_evt_target == 8'd0) ? 8'd1 : cfg_evt_target;
            evt_cnt    <= '0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
            state      <= S_WR_TDR;
          end
        end
        S_WAIT_EVT: begin
          if (abort)         state <= S_WR_STOP;
          else if (evt_edge) state <= S_RD_TSR;
        end
        default: begin
          if (abort) abort_pend <= 1'b1;
          if (!PSEL) begin
            // Launch SETUP; address/control/data then stay frozen until completion.
            PSEL   <= 1'b1;
            PADDR  <= x_addr;
            PWRITE <= x_wr;
            PWDATA <= x_dat;
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= nxt;
            if (PSLVERR) err <= 1'b1;
            if (state == S_RD_TSR) begin
              last_tsr <= PRDATA;
              if (PRDATA[1:0] != 2'b00 && evt_cnt != 8'hFF)
                evt_cnt <= evt_cnt + 8'd1;
            end
            if (nxt == S_WR_STOP || nxt == S_IDLE) abort_pend <= 1'b0;
            if (state == S_WR_STOP) done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
